// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Scheduler state encoding, timeout and parity-sense constants.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } sched_state_t;

    localparam int BUSY_TO = 4;

    localparam logic PARITY_ODD  = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first valid index at or above ptr, modulo NUM_REQ.
module uart_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    // Rotating priority search starting at the pointer.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req_valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter.
// Issues a load strobe, tracks busy, enforces an inter-frame gap.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int GAP_TICKS  = 1,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          tx_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_parity_en,
    input  logic [NUM_REQ-1:0]            req_odd_r_even,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_tick,
    input  logic                          tx_busy,
    output logic                          tx_en,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_parity_en,
    output logic                          tx_odd_r_even_parity,
    output logic [IDW-1:0]                grant_id,
    output logic                          ctl_busy,
    output logic                          frame_done,
    output logic                          err
);

    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

    sched_state_t          state, state_n;
    logic [IDW-1:0]        ptr, ptr_n;
    logic [2:0]            to_cnt, to_cnt_n;
    logic [GW-1:0]         gap_cnt, gap_cnt_n;

    logic                  tx_en_n;
    logic [NUM_REQ-1:0]    req_ready_n;
    logic [DATA_WIDTH-1:0] tx_data_n;
    logic                  tx_parity_en_n;
    logic                  tx_oe_n;
    logic [IDW-1:0]        grant_id_n;
    logic                  frame_done_n;
    logic                  err_n;

    logic [NUM_REQ-1:0]    arb_grant;
    logic [IDW-1:0]        arb_idx;
    logic                  arb_any;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .idx       (arb_idx),
        .any       (arb_any)
    );

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_n        = state;
        ptr_n          = ptr;
        to_cnt_n       = to_cnt;
        gap_cnt_n      = gap_cnt;
        tx_en_n        = 1'b0;
        req_ready_n    = '0;
        tx_data_n      = tx_data;
        tx_parity_en_n = tx_parity_en;
        tx_oe_n        = tx_odd_r_even_parity;
        grant_id_n     = grant_id;
        frame_done_n   = 1'b0;
        err_n          = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (arb_any && !tx_busy) begin
                    state_n        = S_ISSUE;
                    tx_en_n        = 1'b1;
                    req_ready_n    = arb_grant;
                    tx_data_n      = req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                    tx_parity_en_n = req_parity_en[arb_idx];
                    tx_oe_n        = req_odd_r_even[arb_idx];
                    grant_id_n     = arb_idx;
                    ptr_n          = (arb_idx == IDW'(NUM_REQ - 1)) ?
                                     '0 : arb_idx + IDW'(1);
                end
            end
            S_ISSUE: begin
                state_n  = S_WAIT_BUSY;
                to_cnt_n = '0;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = S_WAIT_DONE;
                end else if (to_cnt == 3'(BUSY_TO - 1)) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    to_cnt_n = to_cnt + 3'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    frame_done_n = 1'b1;
                    gap_cnt_n    = '0;
                    state_n      = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (tx_tick) begin
                    gap_cnt_n = gap_cnt + GW'(1);
                    if (int'(gap_cnt) + 1 >= GAP_TICKS) state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, pointer, counters and all outputs registered.
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state                <= S_IDLE;
            ptr                  <= '0;
            to_cnt               <= '0;
            gap_cnt              <= '0;
            tx_en                <= 1'b0;
            req_ready            <= '0;
            tx_data              <= '0;
            tx_parity_en         <= 1'b0;
            tx_odd_r_even_parity <= 1'b0;
            grant_id             <= '0;
            ctl_busy             <= 1'b0;
            frame_done           <= 1'b0;
            err                  <= 1'b0;
        end else begin
            state                <= state_n;
            ptr                  <= ptr_n;
            to_cnt               <= to_cnt_n;
            gap_cnt              <= gap_cnt_n;
            tx_en                <= tx_en_n;
            req_ready            <= req_ready_n;
            tx_data              <= tx_data_n;
            tx_parity_en         <= tx_parity_en_n;
            tx_odd_r_even_parity <= tx_oe_n;
            grant_id             <= grant_id_n;
            ctl_busy             <= (state_n != S_IDLE);
            frame_done           <= frame_done_n;
            err                  <= err_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler.
// The bench plays the transmitter's busy and the baud tick itself.
module tb_uart_tx_scheduler;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int GT = 3;

    logic          tx_clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_parity_en;
    logic [N-1:0]  req_odd_r_even;
    logic [N-1:0]  req_ready;
    logic          tx_tick;
    logic          tx_busy;
    logic          tx_en;
    logic [DW-1:0] tx_data;
    logic          tx_parity_en;
    logic          tx_odd_r_even_parity;
    logic [1:0]    grant_id;
    logic          ctl_busy;
    logic          frame_done;
    logic          err;

    int checks = 0;
    int errors = 0;

    uart_tx_scheduler #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .GAP_TICKS  (GT)
    ) dut (
        .tx_clk               (tx_clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_data             (req_data),
        .req_parity_en        (req_parity_en),
        .req_odd_r_even       (req_odd_r_even),
        .req_ready            (req_ready),
        .tx_tick              (tx_tick),
        .tx_busy              (tx_busy),
        .tx_en                (tx_en),
        .tx_data              (tx_data),
        .tx_parity_en         (tx_parity_en),
        .tx_odd_r_even_parity (tx_odd_r_even_parity),
        .grant_id             (grant_id),
        .ctl_busy             (ctl_busy),
        .frame_done           (frame_done),
        .err                  (err)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic step();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_en"}, 32'(tx_en), 0);
        check({tag, "_ready"}, 32'(req_ready), 0);
        check({tag, "_data"}, 32'(tx_data), 0);
        check({tag, "_pe"}, 32'(tx_parity_en), 0);
        check({tag, "_oe"}, 32'(tx_odd_r_even_parity), 0);
        check({tag, "_gid"}, 32'(grant_id), 0);
        check({tag, "_cbusy"}, 32'(ctl_busy), 0);
        check({tag, "_fdone"}, 32'(frame_done), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    // Called in the cycle tx_en is high; finishes the frame and the gap.
    task automatic serve(input int id, input logic [7:0] d,
                         input logic pe, input logic oe);
        check("issue_tx_en", 32'(tx_en), 1);
        check("issue_ready", 32'(req_ready), 32'(1) << id);
        check("issue_gid", 32'(grant_id), 32'(id));
        check("issue_data", 32'(tx_data), 32'(d));
        check("issue_pe", 32'(tx_parity_en), 32'(pe));
        check("issue_oe", 32'(tx_odd_r_even_parity), 32'(oe));
        check("issue_cbusy", 32'(ctl_busy), 1);
        step();
        check("post_tx_en", 32'(tx_en), 0);
        check("post_ready", 32'(req_ready), 0);
        tx_busy = 1'b1;
        step();
        repeat (3) step();
        check("busy_fdone", 32'(frame_done), 0);
        check("busy_data", 32'(tx_data), 32'(d));
        tx_busy = 1'b0;
        step();
        check("fdone", 32'(frame_done), 1);
        for (int k = 0; k < GT; k++) begin
            step();
            check("gap_fdone", 32'(frame_done), 0);
            check("gap_tx_en", 32'(tx_en), 0);
            tx_tick = 1'b1;
            step();
            tx_tick = 1'b0;
            check("gap_tick_tx_en", 32'(tx_en), 0);
        end
        check("gap_end_cbusy", 32'(ctl_busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        req_valid      = '0;
        req_data       = '0;
        req_parity_en  = '0;
        req_odd_r_even = '0;
        tx_tick        = 1'b0;
        tx_busy        = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;

        // Single request, even parity.
        req_data[7:0]  = 8'hA5;
        req_parity_en  = 4'b0001;
        req_odd_r_even = 4'b0001;
        req_valid      = 4'b0001;
        step();
        req_valid = '0;
        serve(0, 8'hA5, 1'b1, PARITY_EVEN);
        step();
        check("single_no_reissue", 32'(tx_en), 0);

        // All requesting from a fresh pointer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_data       = {8'h44, 8'h33, 8'h22, 8'h11};
        req_parity_en  = 4'b0101;
        req_odd_r_even = 4'b0011;
        req_valid      = 4'b1111;
        step();
        serve(0, 8'h11, 1'b1, 1'b1);
        step();
        serve(1, 8'h22, 1'b0, 1'b1);
        step();
        serve(2, 8'h33, 1'b1, 1'b0);
        step();
        serve(3, 8'h44, 1'b0, 1'b0);

        // Fairness: grant 2, then 1010 gives 3 then 1.
        req_valid = 4'b0100;
        step();
        req_valid = 4'b1010;
        serve(2, 8'h33, 1'b1, 1'b0);
        step();
        serve(3, 8'h44, 1'b0, 1'b0);
        req_valid = 4'b0010;
        step();
        serve(1, 8'h22, 1'b0, 1'b1);
        req_valid = '0;

        // Busy timeout: pointer is at 2.
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        check("to_tx_en", 32'(tx_en), 1);
        check("to_gid", 32'(grant_id), 2);
        for (int k = 0; k < 4; k++) begin
            step();
            check("to_err_early", 32'(err), 0);
            check("to_fdone", 32'(frame_done), 0);
        end
        req_valid = 4'b1100;
        step();
        check("to_err", 32'(err), 1);
        check("to_fdone_at_err", 32'(frame_done), 0);
        check("to_cbusy", 32'(ctl_busy), 0);
        step();
        req_valid = '0;
        check("to_err_pulse", 32'(err), 0);
        serve(3, 8'h44, 1'b0, 1'b0);

        // Reset in WAIT_DONE with a stale busy frame.
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        check("rst_pre_gid", 32'(grant_id), 1);
        step();
        tx_busy = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("midrst");
        req_valid = 4'b0101;
        for (int k = 0; k < 20; k++) begin
            step();
            check("stale_tx_en", 32'(tx_en), 0);
            check("stale_fdone", 32'(frame_done), 0);
        end
        tx_busy = 1'b0;
        step();
        check("post_rst_fdone", 32'(frame_done), 0);
        req_valid = 4'b0100;
        serve(0, 8'h11, 1'b1, 1'b1);
        step();
        req_valid = '0;
        serve(2, 8'h33, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART `transmitter` between `NUM_REQ` byte producers. It arbitrates pending requests and loads the winner's byte and parity configuration into the transmitter with a single-cycle `tx_en`. It then tracks the transmitter's `busy` through the frame and enforces a programmable inter-frame gap in bit ticks. It sits between the host-side byte sources and the `transmitter`, sharing its `tx_clk` and `tx_tick`.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 8: frame data bits; matches the transmitter's `DATA_WIDTH`.
- `GAP_TICKS`, 1: extra idle bit-times after each frame; 0 is legal.
- `IDW`: localparam, `$clog2(NUM_REQ)`.

Ports:
- `tx_clk`  in  1  system clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `req_valid`  in  NUM_REQ  requester i has a byte pending
- `req_data`  in  NUM_REQ*DATA_WIDTH  byte of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_parity_en`  in  NUM_REQ  parity enable for requester i
- `req_odd_r_even`  in  NUM_REQ  parity sense for requester i: 0 odd, 1 even
- `req_ready`  out  NUM_REQ  one-hot, one-cycle pulse; byte i was taken
- `tx_tick`  in  1  baud tick, also fed to the transmitter
- `tx_busy`  in  1  transmitter `busy`
- `tx_en`  out  1  one-cycle load strobe to the transmitter
- `tx_data`  out  DATA_WIDTH  to the transmitter's `data_in`
- `tx_parity_en`  out  1  to the transmitter's `parity_en`
- `tx_odd_r_even_parity`  out  1  to the transmitter's `odd_r_even_parity`
- `grant_id`  out  IDW  index of the current or last granted requester
- `ctl_busy`  out  1  high whenever the FSM is not in IDLE
- `frame_done`  out  1  one-cycle pulse when a frame completes
- `err`  out  1  one-cycle pulse on a busy timeout

## Operation
- All outputs are registered.
- Reset values: all outputs 0, FSM in IDLE, RR pointer 0, counters 0.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE:** when `|req_valid` and `!tx_busy`, the winner w is the first valid index at or above the pointer, searching modulo `NUM_REQ`.
  - Register `tx_data`, `tx_parity_en`, `tx_odd_r_even_parity`, `grant_id` from requester w.
  - Set `req_ready[w]`=1 and `tx_en`=1 for the next cycle.
  - Set pointer to (w+1) mod `NUM_REQ`, then go to ISSUE.
  - No issue while `tx_busy`=1, including a stale frame after a controller-only reset.
- **ISSUE:** lasts exactly 1 cycle with `tx_en`=1 and `req_ready[w]`=1, then goes to WAIT_BUSY.
- **WAIT_BUSY:** on `tx_busy`=1, go to WAIT_DONE.
  - After 4 cycles without busy, pulse `err` and return to IDLE; the byte is dropped and the pointer stays advanced.
- **WAIT_DONE:** on `tx_busy`=0, pulse `frame_done`.
  - Go to GAP with the gap counter at 0, or straight to IDLE when `GAP_TICKS`=0.
- **GAP:** increment the counter on each `tx_tick`. On the tick that makes it equal `GAP_TICKS`, go to IDLE.
- `tx_data` and config are held stable from ISSUE until the next grant.
- Requester rule: `req_valid` and `req_data` are held until `req_ready`. A requester drops or updates them at the edge that ends its ready cycle.
- Reset mid-operation: the FSM returns to IDLE immediately, `tx_en` goes low, and no `frame_done` or `err` is generated for the aborted frame.

## Timing
- `req_valid` sampled in IDLE at cycle t gives `tx_en` and `req_ready` high at t+1.
- With the transmitter attached, `tx_busy` rises at t+2.
- `frame_done` goes high in the cycle after the first cycle `tx_busy` is sampled low.
- Minimum spacing between `tx_en` pulses is one full frame plus `GAP_TICKS` tick periods plus 1 cycle.
- Simultaneous valids are served strictly round-robin. A requester that keeps `req_valid` high waits at most `NUM_REQ`-1 frames.
- `tx_tick` is ignored outside GAP.

## Structure
- Shared package `uart_pkg`:
  - the scheduler state enum (IDLE..GAP, 3 bits);
  - the busy-timeout constant `BUSY_TO`=4;
  - the parity-sense encoding (0 odd, 1 even), shared with `transmitter`.
- Sub-module `uart_rr_arbiter`: combinational, takes `req_valid` and the pointer, returns the one-hot grant and encoded index. The scheduler owns the pointer register.
- Expected size: roughly 150–250 lines of RTL.

## Test plan
- **Single request:** `req_valid`=4'b0001, `req_data[7:0]`=8'hA5, parity_en=1, even → one `tx_en` pulse and `req_ready`=4'b0001 one cycle later. The tx line carries start, A5 LSB first, parity 0, stop. `frame_done` pulses once and `grant_id`=0.
- **All requesting:** `req_valid`=4'b1111 held for four frames → grants in order 0,1,2,3 with distinct bytes transmitted in that order.
- **Fairness:** after a grant to 2, `req_valid`=4'b1010 → grant 3 then 1.
- **Gap:** `GAP_TICKS`=3, back-to-back requests → exactly 3 `tx_tick`s between `frame_done` and the next `tx_en` (plus 1 cycle).
- **Timeout:** `tx_busy` tied 0 → `tx_en`, then `err` pulses exactly 5 cycles after `tx_en`; no `frame_done`; the next request is granted to the next index.
- **Reset mid-frame:** `rst` asserted in WAIT_DONE while `tx_busy` is held 1 for 20 cycles → all outputs 0 and no `tx_en` until `tx_busy` falls. Then the pending request is granted starting from index 0.
